// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared mode encoding, border colour and default geometry for the VGA pattern generator
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_GRID     = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_SOLID    = 2'd3
  } mode_e;

  // Per-channel on/off mask {r,g,b}; each set bit becomes an all-ones channel.
  localparam logic [2:0] BORDER_RGB = 3'b101;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

endpackage

// File: rtl/vga_band_index.sv
// rtl/vga_band_index.sv - maps a column to floor(xe*BANDS/H_ACTIVE) using elaboration-time thresholds
module vga_band_index #(
  parameter int COORD_BITS = 10,
  parameter int H_ACTIVE   = 640,
  parameter int BANDS      = 8,
  parameter int IDX_BITS   = (BANDS > 1) ? $clog2(BANDS) : 1
) (
  input  logic [COORD_BITS-1:0] xe,
  output logic [IDX_BITS-1:0]   idx
);

  logic [BANDS-1:1] at_or_above;

  // Band k starts at the first column where xe*BANDS >= k*H_ACTIVE, i.e. ceil(k*H_ACTIVE/BANDS).
  for (genvar k = 1; k < BANDS; k++) begin : g_thr
    localparam logic [COORD_BITS-1:0] THR = COORD_BITS'((k * H_ACTIVE + BANDS - 1) / BANDS);
    assign at_or_above[k] = (xe >= THR);
  end

  always_comb begin
    idx = '0;
    for (int k = 1; k < BANDS; k++) begin
      if (at_or_above[k]) begin
        idx = IDX_BITS'(k);
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA test-pattern generator, 2-stage pipeline keeping RGB and syncs aligned
// Optional feature macro: PATTERN_SCROLL_EN (patterns 0-2 scroll one pixel per frame).
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int COLOR_BITS = 2,
  parameter int COORD_BITS = 10,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int BORDER     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pixel_active,
  input  logic [COORD_BITS-1:0]   x,
  input  logic [COORD_BITS-1:0]   y,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    mode_step,
  input  logic                    mode_load,
  input  logic [1:0]              mode_sel,
  input  logic [3*COLOR_BITS-1:0] solid_rgb,
  output logic [COLOR_BITS-1:0]   r,
  output logic [COLOR_BITS-1:0]   g,
  output logic [COLOR_BITS-1:0]   b,
  output logic                    hsync,
  output logic                    vsync,
  output logic [1:0]              mode,
  output logic [7:0]              frame_count
);

  localparam int GRAD_BANDS = 1 << COLOR_BITS;

  mode_e      mode_q, mode_d, pend_q, pend_d;
  logic [7:0] fc_q, fc_d;
  logic       vsync_prev_q;
  logic       frame_start;

  logic                    s1_active_q, s1_hs_q, s1_vs_q;
  logic [COORD_BITS-1:0]   s1_x_q, s1_y_q;
  logic [3*COLOR_BITS-1:0] s1_solid_q;

  logic [COORD_BITS-1:0]   xe;
  logic [2:0]              bar_idx, bar_c;
  logic [COLOR_BITS-1:0]   grad_lvl;
  logic                    is_edge;
  logic [COLOR_BITS-1:0]   r_d, g_d, b_d, r_q, g_q, b_q;
  logic                    hs_q, vs_q;

  // Requests only touch the pending mode; the visible mode follows it at frame start,
  // so a request arriving on the frame-start cycle waits for the next frame.
  always_comb begin
    frame_start = vsync_prev_q & ~vsync_in;
    pend_d      = pend_q;
    mode_d      = mode_q;
    fc_d        = fc_q;
    if (mode_load) begin
      pend_d = mode_e'(mode_sel);
    end else if (mode_step) begin
      pend_d = mode_e'(pend_q + 2'd1);
    end
    if (frame_start) begin
      mode_d = pend_q;
      fc_d   = fc_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= MODE_GRID;
      pend_q       <= MODE_GRID;
      fc_q         <= 8'd0;
      vsync_prev_q <= 1'b1;
    end else begin
      mode_q       <= mode_d;
      pend_q       <= pend_d;
      fc_q         <= fc_d;
      vsync_prev_q <= vsync_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_active_q <= 1'b0;
      s1_hs_q     <= 1'b1;
      s1_vs_q     <= 1'b1;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_solid_q  <= '0;
    end else begin
      s1_active_q <= pixel_active;
      s1_hs_q     <= hsync_in;
      s1_vs_q     <= vsync_in;
      s1_x_q      <= x;
      s1_y_q      <= y;
      s1_solid_q  <= solid_rgb;
    end
  end

`ifdef PATTERN_SCROLL_EN
  logic [COORD_BITS:0] xsum;

  always_comb begin
    xsum = (COORD_BITS+1)'(s1_x_q) + (COORD_BITS+1)'(fc_q);
    if (xsum >= (COORD_BITS+1)'(H_ACTIVE)) begin
      xe = COORD_BITS'(xsum - (COORD_BITS+1)'(H_ACTIVE));
    end else begin
      xe = COORD_BITS'(xsum);
    end
  end
`else
  assign xe = s1_x_q;
`endif

  vga_band_index #(
    .COORD_BITS(COORD_BITS),
    .H_ACTIVE  (H_ACTIVE),
    .BANDS     (8),
    .IDX_BITS  (3)
  ) u_bars (
    .xe (xe),
    .idx(bar_idx)
  );

  vga_band_index #(
    .COORD_BITS(COORD_BITS),
    .H_ACTIVE  (H_ACTIVE),
    .BANDS     (GRAD_BANDS),
    .IDX_BITS  (COLOR_BITS)
  ) u_grad (
    .xe (xe),
    .idx(grad_lvl)
  );

  // Border tests the raw column so it stays put when the patterns scroll.
  always_comb begin
    is_edge = (s1_x_q == '0) || (s1_x_q == COORD_BITS'(H_ACTIVE - 1)) ||
              (s1_y_q == '0) || (s1_y_q == COORD_BITS'(V_ACTIVE - 1));
    bar_c   = 3'd7 - bar_idx;
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;
    if (s1_active_q) begin
      if ((BORDER != 0) && is_edge) begin
        r_d = {COLOR_BITS{BORDER_RGB[2]}};
        g_d = {COLOR_BITS{BORDER_RGB[1]}};
        b_d = {COLOR_BITS{BORDER_RGB[0]}};
      end else begin
        case (mode_q)
          MODE_GRID: begin
            r_d = xe[COLOR_BITS+2:3];
            g_d = s1_y_q[COLOR_BITS+2:3];
            b_d = {COLOR_BITS{~(xe[4] ^ s1_y_q[4])}};
          end
          MODE_BARS: begin
            r_d = {COLOR_BITS{bar_c[2]}};
            g_d = {COLOR_BITS{bar_c[1]}};
            b_d = {COLOR_BITS{bar_c[0]}};
          end
          MODE_GRADIENT: begin
            r_d = grad_lvl;
            g_d = grad_lvl;
            b_d = grad_lvl;
          end
          default: begin
            {r_d, g_d, b_d} = s1_solid_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      hs_q <= s1_hs_q;
      vs_q <= s1_vs_q;
    end
  end

  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign mode        = mode_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - self-checking bench for vga_pattern_gen (honours PATTERN_SCROLL_EN)
module tb_vga_pattern_gen;

  localparam int CB = 2;
  localparam int CW = 10;
  localparam int H  = 640;
  localparam int V  = 480;

  logic          clk = 1'b0;
  logic          reset;
  logic          pixel_active;
  logic [CW-1:0] x, y;
  logic          hsync_in, vsync_in, mode_step, mode_load;
  logic [1:0]    mode_sel;
  logic [3*CB-1:0] solid_rgb;
  logic [CB-1:0] r, g, b;
  logic          hsync, vsync;
  logic [1:0]    mode;
  logic [7:0]    frame_count;

  vga_pattern_gen #(
    .COLOR_BITS(CB), .COORD_BITS(CW), .H_ACTIVE(H), .V_ACTIVE(V), .BORDER(1)
  ) dut (
    .clk(clk), .reset(reset), .pixel_active(pixel_active), .x(x), .y(y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mode_step(mode_step),
    .mode_load(mode_load), .mode_sel(mode_sel), .solid_rgb(solid_rgb),
    .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .mode(mode),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [CB-1:0] r;
    logic [CB-1:0] g;
    logic [CB-1:0] b;
    logic          hs;
    logic          vs;
  } exp_t;

  localparam exp_t RST_E = {{(3*CB){1'b0}}, 1'b1, 1'b1};

  int   m_mode, m_pend, m_fc;
  bit   m_vprev;
  bit   m_valid = 1'b0;
  exp_t m_prev, m_cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_rgb(input string name, input logic [3*CB-1:0] req);
    chk(name, 32'({r, g, b}), 32'(req));
  endtask

  // Pixel colour straight from the pattern rules, using whole-number arithmetic.
  function automatic exp_t expect_pix(input bit act, input int xi, input int yi, input bit hs,
                                      input bit vs, input logic [3*CB-1:0] solid, input int md);
    exp_t e;
    int   xe, c, lvl, mask;
    mask = (1 << CB) - 1;
    e    = RST_E;
    e.hs = hs;
    e.vs = vs;
    xe   = xi;
`ifdef PATTERN_SCROLL_EN
    xe = xi + m_fc;
    if (xe >= H) xe = xe - H;
`endif
    if (act) begin
      if (xi == 0 || xi == H - 1 || yi == 0 || yi == V - 1) begin
        e.r = CB'(mask);
        e.b = CB'(mask);
      end else if (md == 0) begin
        e.r = CB'((xe / 8) & mask);
        e.g = CB'((yi / 8) & mask);
        e.b = (((xe / 16) % 2) == ((yi / 16) % 2)) ? CB'(mask) : '0;
      end else if (md == 1) begin
        c   = 7 - (xe * 8 / H);
        e.r = ((c / 4) % 2 == 1) ? CB'(mask) : '0;
        e.g = ((c / 2) % 2 == 1) ? CB'(mask) : '0;
        e.b = (c % 2 == 1) ? CB'(mask) : '0;
      end else if (md == 2) begin
        lvl = xe * (1 << CB) / H;
        e.r = CB'(lvl);
        e.g = CB'(lvl);
        e.b = CB'(lvl);
      end else begin
        e.r = solid[3*CB-1 -: CB];
        e.g = solid[2*CB-1 -: CB];
        e.b = solid[CB-1 -: CB];
      end
    end
    return e;
  endfunction

  // Reference model: what a pixel presented at edge k must look like at the pins after edge k+1.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_cur   = RST_E;
        m_prev  = RST_E;
        m_mode  = 0;
        m_pend  = 0;
        m_fc    = 0;
        m_vprev = 1'b1;
        m_valid = 1'b1;
      end else begin
        m_cur = m_prev;
        if (m_vprev && !vsync_in) begin
          m_fc   = (m_fc + 1) % 256;
          m_mode = m_pend;
        end
        if (mode_load) m_pend = int'(mode_sel);
        else if (mode_step) m_pend = (m_pend + 1) % 4;
        m_vprev = vsync_in;
        m_prev  = expect_pix(pixel_active, int'(x), int'(y), hsync_in, vsync_in, solid_rgb, m_mode);
      end
      @(negedge clk);
      if (m_valid) begin
        chk("model_pins", 32'({r, g, b, hsync, vsync}), 32'(m_cur));
        chk("model_mode", 32'(mode), 32'(m_mode));
        chk("model_frame_count", 32'(frame_count), 32'(m_fc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pixel_active = 1'b0;
    x            = '0;
    y            = '0;
    hsync_in     = 1'b1;
    mode_step    = 1'b0;
    mode_load    = 1'b0;
  endtask

  task automatic pix(input int xi, input int yi, input bit act, input logic [3*CB-1:0] req,
                     input string name);
    pixel_active = act;
    x            = CW'(xi);
    y            = CW'(yi);
    tick(1);
    idle();
    @(posedge clk);
    @(negedge clk);
    chk_rgb(name, req);
  endtask

  task automatic frame();
    vsync_in = 1'b0;
    tick(1);
    vsync_in = 1'b1;
  endtask

  task automatic sweep(input int step);
    for (int xx = 0; xx < H; xx += step) begin
      pixel_active = (xx % 5 != 0);
      x            = CW'(xx);
      y            = CW'((xx * 7) % V);
      hsync_in     = (xx % 3 != 0);
      tick(1);
    end
    idle();
    tick(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    vsync_in  = 1'b1;
    mode_sel  = 2'd0;
    solid_rgb = '0;
    idle();
    tick(3);
    chk_rgb("reset_rgb", 6'b000000);
    chk("reset_hsync", 32'(hsync), 32'd1);
    chk("reset_vsync", 32'(vsync), 32'd1);
    chk("reset_mode", 32'(mode), 32'd0);
    chk("reset_frame_count", 32'(frame_count), 32'd0);
    reset = 1'b0;
    tick(2);

    // Grid pixel with a coincident hsync pulse: both must emerge two edges later.
    pixel_active = 1'b1;
    x            = 10'd13;
    y            = 10'd24;
    hsync_in     = 1'b0;
    tick(1);
    idle();
    chk("hsync_one_edge", 32'(hsync), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk_rgb("grid_13_24", 6'b011100);
    chk("hsync_two_edges", 32'(hsync), 32'd0);
    @(negedge clk);
    chk("hsync_released", 32'(hsync), 32'd1);

    pix(0, 100, 1'b1, 6'b110011, "border_left");
    pix(639, 200, 1'b1, 6'b110011, "border_right");
    pix(300, 479, 1'b1, 6'b110011, "border_bottom");
    pix(0, 100, 1'b0, 6'b000000, "inactive_blank");
    sweep(23);

    mode_step = 1'b1;
    tick(1);
    mode_step = 1'b0;
    tick(3);
    chk("step_waits_frame", 32'(mode), 32'd0);
    frame();
    chk("step_commits", 32'(mode), 32'd1);
    pix(40, 100, 1'b1, 6'b111111, "bars_x40");
    pix(80, 100, 1'b1, 6'b111100, "bars_x80");
    pix(600, 100, 1'b1, 6'b000000, "bars_x600");
    sweep(19);

    solid_rgb = 6'b010110;
    mode_sel  = 2'd3;
    mode_load = 1'b1;
    mode_step = 1'b1;
    tick(1);
    mode_load = 1'b0;
    mode_step = 1'b0;
    tick(2);
    chk("load_waits_frame", 32'(mode), 32'd1);
    frame();
    chk("load_beats_step", 32'(mode), 32'd3);
    pix(100, 100, 1'b1, 6'b010110, "solid_interior");
    sweep(29);

    mode_step = 1'b1;
    vsync_in  = 1'b0;
    tick(1);
    mode_step = 1'b0;
    vsync_in  = 1'b1;
    chk("fs_request_held", 32'(mode), 32'd3);
    tick(2);
    frame();
    chk("fs_request_next", 32'(mode), 32'd0);
    sweep(31);

    mode_sel  = 2'd2;
    mode_load = 1'b1;
    tick(1);
    mode_load = 1'b0;
    frame();
    chk("gradient_mode", 32'(mode), 32'd2);
    pix(170, 100, 1'b1, 6'b010101, "gradient_x170");
    pix(500, 100, 1'b1, 6'b111111, "gradient_x500");
    chk("frame_count_5", 32'(frame_count), 32'd5);
    sweep(17);

    mode_sel  = 2'd1;
    mode_load = 1'b1;
    tick(1);
    mode_load = 1'b0;
    frame();
    chk("frame_count_6", 32'(frame_count), 32'd6);
`ifdef PATTERN_SCROLL_EN
    pix(75, 100, 1'b1, 6'b111100, "scroll_x75");
    pix(636, 100, 1'b1, 6'b111111, "scroll_x636");
`else
    pix(75, 100, 1'b1, 6'b111111, "bars_x75");
    pix(636, 100, 1'b1, 6'b000000, "bars_x636");
`endif
    sweep(13);

    repeat (250) begin
      frame();
      tick(1);
    end
    chk("frame_count_wrap", 32'(frame_count), 32'd0);
    frame();
    chk("frame_count_after_wrap", 32'(frame_count), 32'd1);

    pixel_active = 1'b1;
    x            = 10'd100;
    y            = 10'd100;
    tick(1);
    reset = 1'b1;
    tick(1);
    chk_rgb("midframe_reset_rgb", 6'b000000);
    chk("midframe_reset_mode", 32'(mode), 32'd0);
    chk("midframe_reset_frame_count", 32'(frame_count), 32'd0);
    reset = 1'b0;
    idle();
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
